// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage integer divider: FSM states,
// funct3 encodings of the divide/remainder instructions and an
// opcode decode helper.
package ex_div_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3 encodings of the M-extension divide group
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic is_div_grp;  // funct3 belongs to the divide group
    logic is_signed;   // DIV / REM
    logic is_rem;      // REM / REMU return the remainder
  } div_op_t;

  // Decode the funct3 field into the few properties the divider needs.
  function automatic div_op_t decode_op(input logic [2:0] f3);
    div_op_t op;
    op.is_div_grp = f3[2];
    op.is_signed  = ~f3[0];
    op.is_rem     = f3[1];
    return op;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// Handshake between the EX stage / hazard unit and the iterative divider.
interface ex_div_if
  import ex_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            StartE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            StallDiv;
  logic            DivBusy;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  // pipeline side: issues the operation, consumes stall and result
  modport master (
    output StartE, funct3E, SrcAE, SrcBE, FlushE,
    input  StallDiv, DivBusy, DivDoneE, DivResultE
  );

  // divider side
  modport slave (
    input  StartE, funct3E, SrcAE, SrcBE, FlushE,
    output StallDiv, DivBusy, DivDoneE, DivResultE
  );
endinterface

// File: rtl/ex_div_step.sv
// One combinational restoring-division step. The partial remainder is
// shifted left by one with the next dividend bit appended and the divisor
// is trial-subtracted in XLEN+1 bits; the sign of the difference decides
// the quotient bit and whether the subtraction is kept.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] partial_s;
  logic [XLEN:0] diff_s;

  assign partial_s = {rem_in, dividend_bit};
  assign diff_s    = partial_s - {1'b0, divisor};

  // Invariant rem_in < divisor keeps a non-negative difference inside XLEN
  // bits, so diff_s[XLEN] is a clean "borrow" flag.
  assign q_bit   = ~diff_s[XLEN];
  assign rem_out = q_bit ? diff_s[XLEN-1:0] : {rem_in[XLEN-2:0], dividend_bit};

endmodule

// File: rtl/ex_div_controller.sv
// Multi-cycle restoring divider for the EX stage. Holds the pipeline with
// StallDiv while iterating one quotient bit per cycle, then presents a
// signed/unsigned quotient or remainder with a one-cycle DivDoneE pulse.
// Divide-by-zero and signed overflow bypass the iteration.
module ex_div_controller
  import ex_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic     clk,
  input logic     reset,
  ex_div_if.slave div_bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  div_state_e      state_r;
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;       // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] dvsr_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic            rem_op_r;
  logic [XLEN-1:0] result_r;

  div_op_t         op_s;
  logic            start_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] abs_a_s;
  logic [XLEN-1:0] abs_b_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic [XLEN-1:0] rem_nxt_s;
  logic            q_bit_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;

  assign op_s       = decode_op(div_bus.funct3E);
  // a flush in the same cycle kills the instruction before it starts
  assign start_s    = (state_r == IDLE) && div_bus.StartE && !div_bus.FlushE && op_s.is_div_grp;
  assign a_neg_s    = op_s.is_signed & div_bus.SrcAE[XLEN-1];
  assign b_neg_s    = op_s.is_signed & div_bus.SrcBE[XLEN-1];
  assign abs_a_s    = a_neg_s ? (~div_bus.SrcAE + ONE) : div_bus.SrcAE;
  assign abs_b_s    = b_neg_s ? (~div_bus.SrcBE + ONE) : div_bus.SrcBE;
  assign div_zero_s = (div_bus.SrcBE == ZERO);
  assign ovf_s      = op_s.is_signed && (div_bus.SrcAE == MIN_NEG) && (div_bus.SrcBE == ALL_ONES);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in       (rem_r),
    .dividend_bit (quo_r[XLEN-1]),
    .divisor      (dvsr_r),
    .rem_out      (rem_nxt_s),
    .q_bit        (q_bit_s)
  );

  assign quo_fix_s = neg_q_r ? (~quo_r + ONE) : quo_r;
  assign rem_fix_s = neg_r_r ? (~rem_r + ONE) : rem_r;

  // Stall is combinational so the start cycle itself already holds F/D/E;
  // gated by reset so it drops as soon as reset is asserted.
  assign div_bus.StallDiv   = reset && (start_s || (state_r == CALC) || (state_r == FIX));
  assign div_bus.DivBusy    = (state_r != IDLE);
  assign div_bus.DivDoneE   = (state_r == DONE);
  assign div_bus.DivResultE = result_r;

  // Divider FSM: operand capture, iteration, sign fix-up and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      count_r  <= CNT_ZERO;
      rem_r    <= ZERO;
      quo_r    <= ZERO;
      dvsr_r   <= ZERO;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      rem_op_r <= 1'b0;
      result_r <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            if (div_zero_s) begin
              result_r <= op_s.is_rem ? div_bus.SrcAE : ALL_ONES;
              state_r  <= DONE;
            end else if (ovf_s) begin
              result_r <= op_s.is_rem ? ZERO : MIN_NEG;
              state_r  <= DONE;
            end else begin
              rem_r    <= ZERO;
              quo_r    <= abs_a_s;
              dvsr_r   <= abs_b_s;
              count_r  <= CNT_INIT;
              neg_q_r  <= a_neg_s ^ b_neg_s;
              neg_r_r  <= a_neg_s;
              rem_op_r <= op_s.is_rem;
              state_r  <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (div_bus.FlushE) begin
            state_r <= IDLE;
          end else begin
            rem_r <= rem_nxt_s;
            quo_r <= {quo_r[XLEN-2:0], q_bit_s};
            if (count_r == CNT_ZERO) begin
              state_r <= FIX;
            end else begin
              count_r <= count_r - CNT_ONE;
              state_r <= CALC;
            end
          end
        end
        FIX: begin
          if (div_bus.FlushE) begin
            state_r <= IDLE;
          end else begin
            result_r <= rem_op_r ? rem_fix_s : quo_fix_s;
            state_r  <= DONE;
          end
        end
        DONE: begin
          // the instruction is still in EX this cycle; its StartE is ignored
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_controller.sv
// Directed bench for ex_div_controller: stall length, results, special
// cases, flush and asynchronous reset behaviour.
module tb_ex_div_controller;
  import ex_div_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_div_if #(.XLEN(32)) bus ();

  ex_div_controller #(.XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .div_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation just after a rising edge, hold StartE while stalled
  // and through the done cycle, then check stall count and result.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input logic [31:0] exp_res);
    int          stalls;
    bit          done;
    logic [31:0] res;
    logic        stall_at_done;
    stalls = 0;
    done = 1'b0;
    res = 32'h0;
    stall_at_done = 1'b1;
    bus.StartE  = 1'b1;
    bus.funct3E = f3;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (bus.DivDoneE) begin
        done = 1'b1;
        res = bus.DivResultE;
        stall_at_done = bus.StallDiv;
      end else if (bus.StallDiv) begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.StartE = 1'b0;
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " stalls"}, stalls, exp_stall);
    check({tag, " result"}, res, exp_res);
    check({tag, " stall@done"}, {31'd0, stall_at_done}, 32'd0);
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, bus.DivDoneE}, 32'd0);
    check({tag, " idle after"}, {31'd0, bus.DivBusy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.StartE = 1'b0;
    bus.funct3E = 3'b000;
    bus.SrcAE = 32'h0;
    bus.SrcBE = 32'h0;
    bus.FlushE = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst stall", {31'd0, bus.StallDiv}, 32'd0);
    check("rst busy", {31'd0, bus.DivBusy}, 32'd0);
    check("rst done", {31'd0, bus.DivDoneE}, 32'd0);
    check("rst result", bus.DivResultE, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("divu 100/7", F3_DIVU, 32'd100, 32'd7, 34, 32'd14);
    run_op("remu 100/7", F3_REMU, 32'd100, 32'd7, 34, 32'd2);
    run_op("div -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
    run_op("rem -7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
    run_op("divu 5/0", F3_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("remu 5/0", F3_REMU, 32'd5, 32'd0, 1, 32'd5);
    run_op("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
    run_op("div 7/-2", F3_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD);
    run_op("rem 7/-2", F3_REM, 32'd7, 32'hFFFF_FFFE, 34, 32'd1);

    // flush together with start in IDLE: no start
    bus.StartE = 1'b1;
    bus.funct3E = F3_DIVU;
    bus.SrcAE = 32'd50;
    bus.SrcBE = 32'd5;
    bus.FlushE = 1'b1;
    @(negedge clk);
    check("flush@start stall", {31'd0, bus.StallDiv}, 32'd0);
    @(posedge clk);
    #1;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    @(negedge clk);
    check("flush@start busy", {31'd0, bus.DivBusy}, 32'd0);
    @(posedge clk);
    #1;

    // flush in CALC cycle 10
    bus.StartE = 1'b1;
    bus.funct3E = F3_DIVU;
    bus.SrcAE = 32'd1000;
    bus.SrcBE = 32'd3;
    @(negedge clk);
    check("flush start stall", {31'd0, bus.StallDiv}, 32'd1);
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    bus.FlushE = 1'b1;
    @(negedge clk);
    check("calc10 busy", {31'd0, bus.DivBusy}, 32'd1);
    check("calc10 stall", {31'd0, bus.StallDiv}, 32'd1);
    @(posedge clk);
    #1;
    bus.FlushE = 1'b0;
    bus.StartE = 1'b0;
    @(negedge clk);
    check("post-flush busy", {31'd0, bus.DivBusy}, 32'd0);
    check("post-flush stall", {31'd0, bus.StallDiv}, 32'd0);
    check("post-flush result", bus.DivResultE, 32'd1);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.DivDoneE) done_cnt++;
      @(negedge clk);
    end
    check("post-flush no done", done_cnt, 0);
    @(posedge clk);
    #1;
    run_op("divu 9/3", F3_DIVU, 32'd9, 32'd3, 34, 32'd3);

    // asynchronous reset in the middle of CALC
    bus.StartE = 1'b1;
    bus.funct3E = F3_DIVU;
    bus.SrcAE = 32'd1000;
    bus.SrcBE = 32'd7;
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst stall", {31'd0, bus.StallDiv}, 32'd0);
    check("midrst busy", {31'd0, bus.DivBusy}, 32'd0);
    check("midrst done", {31'd0, bus.DivDoneE}, 32'd0);
    check("midrst result", bus.DivResultE, 32'h0);
    @(negedge clk);
    bus.StartE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_op("divu 20/4", F3_DIVU, 32'd20, 32'd4, 34, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_controller.md
EX_DIV_CONTROLLER -- requirements
Module: ex_div_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port StartE  input  1  a DIV/DIVU/REM/REMU instruction is valid in EX.
REQ-005 SHALL have port funct3E  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port SrcAE  input  XLEN  dividend after forwarding.
REQ-007 SHALL have port SrcBE  input  XLEN  divisor after forwarding.
REQ-008 SHALL have port FlushE  input  1  EX-stage flush from the hazard unit.
REQ-009 SHALL have port StallDiv  output  1  stall request for the F, D and E pipeline registers.
REQ-010 SHALL have port DivBusy  output  1  FSM not in IDLE.
REQ-011 SHALL have port DivDoneE  output  1  single-cycle pulse; DivResultE valid.
REQ-012 SHALL have port DivResultE  output  XLEN  quotient or remainder per funct3E.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 IDLE with StartE=1 and no special case SHALL drive StallDiv=1 combinationally, latch |SrcAE|, |SrcBE| (signed ops), the signs, op and a count of XLEN-1, then go to CALC.
REQ-015 CALC SHALL perform one restoring-division step per cycle for exactly XLEN cycles, decrementing the count, then go to FIX.
REQ-016 FIX SHALL apply signs (quotient negated if signs differ; remainder takes the dividend sign), register DivResultE and go to DONE.
REQ-017 DONE SHALL assert DivDoneE=1 and StallDiv=0 for one cycle, then go to IDLE; StartE in DONE SHALL be ignored.
REQ-018 StallDiv SHALL be 1 in the start cycle and in every CALC and FIX cycle: 1+XLEN+1 = 34 stall cycles, with DivDoneE in cycle 35.
REQ-019 On divisor zero, IDLE SHALL go directly to DONE with quotient all ones and remainder = SrcAE, and 1 stall cycle.
REQ-020 On DIV/REM with SrcAE=0x80000000 and SrcBE=0xFFFFFFFF, IDLE SHALL go directly to DONE with quotient 0x80000000 and remainder 0, and 1 stall cycle.
REQ-021 FlushE=1 in CALC or FIX SHALL return the FSM to IDLE at the next edge, with no DivDoneE and DivResultE unchanged.
REQ-022 FlushE=1 together with StartE in IDLE SHALL suppress the start.
REQ-023 StartE in CALC or FIX SHALL be ignored, because the stalled instruction is the same instruction.
REQ-024 DivResultE SHALL hold its value until the next FIX or special-case DONE.
REQ-025 All arithmetic SHALL be XLEN bits, with an XLEN+1-bit partial remainder inside the step.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, count 0, DivResultE 0, StallDiv 0, DivBusy 0 and DivDoneE 0, including mid-CALC.
REQ-027 On release, the first StartE SHALL be accepted at the next rising edge.

Structure
REQ-028 Package ex_div_pkg SHALL hold the state enum, the funct3 codes (DIV, DIVU, REM, REMU) and XLEN default.
REQ-029 A sub-module div_step SHALL implement one combinational restoring step: inputs partial remainder and dividend bit; outputs new remainder and quotient bit.

Verification
REQ-030 DIVU 100/7 SHALL give StallDiv for 34 cycles, then DivDoneE with DivResultE=14; REMU SHALL give 2.
REQ-031 DIV -7/2 SHALL give 0xFFFFFFFD (-3); REM -7/2 SHALL give 0xFFFFFFFF (-1).
REQ-032 DIVU 5/0 SHALL give 1 stall cycle and result 0xFFFFFFFF; REMU 5/0 SHALL give 5.
REQ-033 DIV 0x80000000/0xFFFFFFFF SHALL give 0x80000000; REM SHALL give 0; each with 1 stall cycle.
REQ-034 FlushE pulsed in CALC cycle 10 SHALL return the FSM to IDLE next cycle, drop StallDiv and produce no DivDoneE; a following DIVU 9/3 SHALL return 3.
REQ-035 reset=0 asserted mid-CALC SHALL zero all outputs immediately; after release, DIVU 20/4 SHALL return 5.
